mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Moore control FSM that sequences the multicycle MIPS32 datapath: fetch, decode, execute, memory and writeback.
- Sits between the instruction register's opcode field and the datapath enables: PC, IR, register file, ALU muxes and memory/IO strobes.
- One instruction completes every 3-5 cycles. The datapath owns all data; this block owns only sequencing.

Parameters:
- OPC_W, 6, opcode field width (instr[31:26]).
- STATE_W, 4, width of the state encoding and of the debug state output.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  OPC_W  IR[31:26], valid from DECODE onward.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if ALU zero (datapath ANDs with zero).
- iord  output  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  output  1  memory/IO read strobe.
- mem_write  output  1  memory/IO write strobe.
- ir_write  output  1  IR load enable.
- mem_to_reg  output  1  writeback select: 0=ALUOut, 1=MDR.
- reg_dst  output  1  destination select: 0=rt, 1=rd.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  ALU A select: 0=PC, 1=A register.
- alu_src_b  output  2  ALU B select: 00=B, 01=const 4, 10=signext imm, 11=signext imm<<2.
- alu_op  output  2  00=add, 01=sub, 10=funct-decoded.
- pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target.
- state  output  STATE_W  current state, for debug.
- illegal_op  output  1  one-cycle pulse on an undecodable opcode.

Behaviour:
- Reset:
  - rst is sampled on the clk rising edge; while high, the next state is FETCH.
  - Every control output is 0 during any cycle in which rst is high, including the first post-reset FETCH edge.
  - rst mid-instruction abandons the instruction; no write strobe fires on the reset cycle.
- Outputs are a pure function of the registered state: Moore, no input-to-output path, except illegal_op.
- Unlisted outputs are 0 in each state below.
- States and transitions:
  - FETCH (0): mem_read, ir_write, alu_src_b=01, alu_op=00, pc_write, pc_source=00. Next: DECODE.
  - DECODE (1): alu_src_b=11, alu_op=00 (precompute branch target). Next by opcode:
    - 0x23 or 0x2B -> MEMADR
    - 0x00 -> RTYPE
    - 0x04 -> BEQ
    - 0x08 -> ADDI_EX
    - 0x02 -> JUMP
    - any other opcode -> FETCH, with illegal_op=1 for that cycle.
  - MEMADR (2): alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEMRD if opcode=0x23, else MEMWR.
  - MEMRD (3): mem_read, iord. Next: MEMWB.
  - MEMWB (4): reg_write, mem_to_reg=1, reg_dst=0. Next: FETCH.
  - MEMWR (5): mem_write, iord. Next: FETCH.
  - RTYPE (6): alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
  - ALUWB (7): reg_write, reg_dst=1, mem_to_reg=0. Next: FETCH.
  - BEQ (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01. Next: FETCH.
  - ADDI_EX (9): alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDI_WB.
  - ADDI_WB (10): reg_write, reg_dst=0, mem_to_reg=0. Next: FETCH.
  - JUMP (11): pc_write, pc_source=10. Next: FETCH.
  - Encodings 12-15 are unreachable; if entered they go to FETCH with all outputs 0.
- Cycles per instruction:
  - LW 5; SW, R-type and ADDI 4; BEQ and J 3; illegal opcode 2.
- Invariants:
  - mem_read and mem_write are never both high.
  - pc_write and pc_write_cond are never both high.
  - reg_write is never high in FETCH or DECODE.
- opcode is only sampled in DECODE and MEMADR. IR is stable there because ir_write is high only in FETCH.

Optional Feature:
- Macro: MIPS_CTRL_MEM_WAIT_EN.
- With the macro defined:
  - Adds input mem_ready (1 bit).
  - FETCH, MEMRD and MEMWR hold their state and outputs until mem_ready=1; the transition occurs on the edge where mem_ready=1.
  - In FETCH, pc_write and ir_write are gated by mem_ready, so PC increments exactly once per fetch.
  - No timeout.
- Without the macro: no mem_ready port; memory is single-cycle and the latencies above are exact.

Decomposition:
- Package mips_ctrl_pkg:
  - state encodings (localparams S_FETCH..S_JUMP);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - ALUOp, ALUSrcB and PCSource codes, shared with the ALU-control decoder and the datapath.
- Structure: a single module with a state register plus a next-state/output always block. No sub-module is needed.
- ALU funct decoding stays in the existing ALU-control block.

Test Plan:
- Reset: rst=1 for 2 cycles with opcode=0x23 -> all outputs 0, state=0. After release -> FETCH outputs (mem_read=1, ir_write=1, pc_write=1, alu_src_b=01).
- LW sequence: opcode=0x23 -> states 0,1,2,3,4,0. mem_read with iord=1 in state 3; reg_write with mem_to_reg=1 in state 4. Exactly 5 cycles.
- Mixed program, opcodes 0x00, 0x2B, 0x04, 0x08, 0x02 back-to-back -> 4, 4, 3, 4, 3 cycles respectively. pc_write_cond asserted only in the BEQ state. mem_write asserted only in the SW state.
- Illegal opcode 0x3F -> DECODE then FETCH; illegal_op high for exactly 1 cycle; no reg_write or mem_write.
- Reset mid-instruction: rst asserted during MEMWR -> no mem_write that cycle; state=FETCH after release.
- With MIPS_CTRL_MEM_WAIT_EN and mem_ready low 3 cycles in MEMRD -> state held 4 cycles; LW total 8 cycles; pc_write pulses exactly once.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes,
// ALU/PC mux codes and the per-state Moore output table.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPE   = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // Control word asserted while the FSM sits in state s; unused encodings are all-zero.
  function automatic ctrl_t ctrl_of(input logic [3:0] s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_ALU;
      end
      S_DECODE:  c.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_RTYPE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Moore sequencer for the multicycle MIPS datapath (FETCH..writeback).
// Define MIPS_CTRL_MEM_WAIT_EN to add mem_ready and stall FETCH/MEMRD/MEMWR on slow memory.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPC_W   = 6,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
`ifdef MIPS_CTRL_MEM_WAIT_EN
  input  logic               mem_ready,
`endif
  input  logic [OPC_W-1:0]   opcode,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic [STATE_W-1:0] state,
  output logic               illegal_op
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_out;
  logic   mem_ok;
  logic   is_mem_op;
  logic   opc_legal;

`ifdef MIPS_CTRL_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  assign is_mem_op = (opcode == OPC_W'(OP_LW)) || (opcode == OPC_W'(OP_SW));
  assign opc_legal = is_mem_op
                  || (opcode == OPC_W'(OP_RTYPE))
                  || (opcode == OPC_W'(OP_BEQ))
                  || (opcode == OPC_W'(OP_ADDI))
                  || (opcode == OPC_W'(OP_J));

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_mem_op)                         state_d = S_MEMADR;
        else if (opcode == OPC_W'(OP_RTYPE))   state_d = S_RTYPE;
        else if (opcode == OPC_W'(OP_BEQ))     state_d = S_BEQ;
        else if (opcode == OPC_W'(OP_ADDI))    state_d = S_ADDI_EX;
        else if (opcode == OPC_W'(OP_J))       state_d = S_JUMP;
        else                                   state_d = S_FETCH;
      end
      S_MEMADR:  state_d = (opcode == OPC_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ok ? S_FETCH : S_MEMWR;
      S_RTYPE:   state_d = S_ALUWB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      default:   state_d = S_FETCH;
    endcase
  end

  // The control word is registered alongside the state so ctrl_q always equals ctrl_of(state_q).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_of(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d);
    end
  end

  // Reset blanks every strobe in the same cycle so an abandoned instruction cannot write.
  always_comb begin
    ctrl_out = rst ? '0 : ctrl_q;
    if (state_q == S_FETCH && !mem_ok) begin
      ctrl_out.pc_write = 1'b0;
      ctrl_out.ir_write = 1'b0;
    end
  end

  assign pc_write      = ctrl_out.pc_write;
  assign pc_write_cond = ctrl_out.pc_write_cond;
  assign iord          = ctrl_out.iord;
  assign mem_read      = ctrl_out.mem_read;
  assign mem_write     = ctrl_out.mem_write;
  assign ir_write      = ctrl_out.ir_write;
  assign mem_to_reg    = ctrl_out.mem_to_reg;
  assign reg_dst       = ctrl_out.reg_dst;
  assign reg_write     = ctrl_out.reg_write;
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign alu_src_b     = ctrl_out.alu_src_b;
  assign alu_op        = ctrl_out.alu_op;
  assign pc_source     = ctrl_out.pc_source;
  assign state         = STATE_W'(state_q);
  assign illegal_op    = !rst && (state_q == S_DECODE) && !opc_legal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized instruction stream against an instruction-level reference model;
// per-cycle expectations are queued by the driver and checked by a negedge monitor.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'h23;
`ifdef MIPS_CTRL_MEM_WAIT_EN
  logic       mem_ready = 1'b1;
`endif
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.OPC_W(6), .STATE_W(4)) dut (
    .clk(clk),
    .rst(rst),
`ifdef MIPS_CTRL_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .opcode(opcode),
    .pc_write(pc_write),
    .pc_write_cond(pc_write_cond),
    .iord(iord),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .ir_write(ir_write),
    .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst),
    .reg_write(reg_write),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .alu_op(alu_op),
    .pc_source(pc_source),
    .state(state),
    .illegal_op(illegal_op)
  );

  typedef struct packed {
    logic [31:0] inst_no;
    logic [5:0]  op;
    logic [3:0]  st;
    logic [16:0] outs;
  } exp_t;

  exp_t        sbq[$];
  int          path_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          inst_no = 0;
  logic [16:0] act;

  assign act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

  // Reference output table, one entry per named step of an instruction.
  function automatic logic [16:0] spec_outs(input int st, input bit ready, input bit illegal);
    logic pcw, pcwc, ia, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] srcb, aop, ps;
    {pcw, pcwc, ia, mr, mw, irw, m2r, rd, rw, sa} = '0;
    srcb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (st)
      0:  begin mr = 1; irw = ready; pcw = ready; srcb = 2'b01; end
      1:  srcb = 2'b11;
      2:  begin sa = 1; srcb = 2'b10; end
      3:  begin mr = 1; ia = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; ia = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; aop = 2'b01; pcwc = 1; ps = 2'b01; end
      9:  begin sa = 1; srcb = 2'b10; end
      10: rw = 1;
      11: begin pcw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, ia, mr, mw, irw, m2r, rd, rw, sa, srcb, aop, ps, (st == 1) && illegal};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'h23 || op == 6'h2B || op == 6'h00 || op == 6'h04 || op == 6'h08 || op == 6'h02;
  endfunction

  // Steps each instruction class walks through, from its fetch to its last cycle.
  task automatic build_path(input logic [5:0] op);
    case (op)
      6'h23:   path_q = '{0, 1, 2, 3, 4};
      6'h2B:   path_q = '{0, 1, 2, 5};
      6'h00:   path_q = '{0, 1, 6, 7};
      6'h04:   path_q = '{0, 1, 8};
      6'h08:   path_q = '{0, 1, 9, 10};
      6'h02:   path_q = '{0, 1, 11};
      default: path_q = '{0, 1};
    endcase
  endtask

  task automatic push_exp(input int st, input logic [16:0] outs);
    exp_t e;
    e.inst_no = 32'(inst_no);
    e.op      = opcode;
    e.st      = 4'(st);
    e.outs    = outs;
    sbq.push_back(e);
  endtask

  // Runs one instruction; rst_at >= 0 raises reset on that step and abandons the rest.
  task automatic run_inst(input logic [5:0] op, input int rst_at);
    bit ready;
    inst_no++;
    build_path(op);
    for (int k = 0; k < path_q.size(); k++) begin
      int st;
      st = path_q[k];
      forever begin
        @(posedge clk); #1;
        opcode = op;
        ready  = 1'b1;
`ifdef MIPS_CTRL_MEM_WAIT_EN
        if ((st == 0 || st == 3 || st == 5) && k != rst_at)
          ready = ($urandom_range(0, 2) != 0);
        mem_ready = ready;
`endif
        if (k == rst_at) begin
          rst = 1'b1;
          push_exp(st, 17'd0);
          break;
        end
        rst = 1'b0;
        push_exp(st, spec_outs(st, ready, !is_legal(op)));
        if (ready) break;
      end
      if (k == rst_at) break;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      vectors++;
      if (state !== e.st || act !== e.outs) begin
        miscompares++;
        $display("FAIL inst %0d op=%02h: state=%0d outs=%b, required state=%0d outs=%b",
                 e.inst_no, e.op, state, act, e.st, e.outs);
      end else begin
        $display("ok   inst %0d op=%02h state=%0d outs=%b", e.inst_no, e.op, state, act);
      end
    end
  end

  logic [5:0] legal_ops [6];

  initial begin
    int r;
    logic [5:0] op;
    legal_ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};

    // Reset held for two cycles with a load opcode present.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      opcode = 6'h23;
      push_exp(0, 17'd0);
    end

    run_inst(6'h23, -1);
    run_inst(6'h00, -1);
    run_inst(6'h2B, -1);
    run_inst(6'h04, -1);
    run_inst(6'h08, -1);
    run_inst(6'h02, -1);
    run_inst(6'h3F, -1);
    run_inst(6'h2B, 3);
    run_inst(6'h23, -1);

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r == 6) op = 6'($urandom_range(0, 63));
      else        op = legal_ops[r % 6];
      build_path(op);
      if ($urandom_range(0, 11) == 0)
        run_inst(op, $urandom_range(0, path_q.size() - 1));
      else
        run_inst(op, -1);
    end

    @(posedge clk); #1;
    @(negedge clk); #1;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
